// File: rtl/flash_read_master_pkg.sv
// rtl/flash_read_master_pkg.sv - shared flash command codes, widths and FSM state type
package flash_read_master_pkg;
   localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
   localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
   localparam int unsigned FLASH_ADDR_BITS    = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_DONE,
      ST_GAP
   } flash_state_e;

   // Bytes arrive first-byte-first; the returned word is little-endian.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/flash_read_master_spi_clk_gen.sv
// rtl/flash_read_master_spi_clk_gen.sv - SPI mode-0 clock generator with rise/fall strobes
module spi_clk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int unsigned CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;

   // Strobes flag the cycle whose closing edge moves sclk.
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      rise_o = 1'b0;
      fall_o = 1'b0;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
         rise_o = ~sclk_q;
         fall_o = sclk_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
endmodule

// File: rtl/flash_read_master.sv
// rtl/flash_read_master.sv - single-word SPI flash read initiator
// FLASH_FAST_READ_EN selects command 0x0B with 8 dummy clocks after the address.
module flash_read_master
   import flash_read_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned CS_GAP  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [FLASH_ADDR_BITS-1:0] addr_i,
   input  logic                       rd_stb_i,
   output logic                       busy_o,
   output logic                       ack_o,
   output logic [31:0]                data_o,
   output logic                       flash_csn,
   output logic                       flash_clk,
   output logic                       flash_mosi,
   input  logic                       flash_miso,
   output logic                       flash_wpn,
   output logic                       flash_holdn
);
`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] CMD       = FLASH_CMD_FAST_READ;
   localparam bit         HAS_DUMMY = 1'b1;
`else
   localparam logic [7:0] CMD       = FLASH_CMD_READ;
   localparam bit         HAS_DUMMY = 1'b0;
`endif

   flash_state_e state_q, state_d;
   logic         csn_q, csn_d, mosi_q, mosi_d, ack_q, ack_d, busy_q, busy_d;
   logic [31:0]  data_q, data_d, tx_q, tx_d, rx_q, rx_d;
   logic [6:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]   gap_cnt_q, gap_cnt_d;
   logic         sclk_rise, sclk_fall, sclk_en;

   // The clock stops once the last bit has fallen, before csn is released.
   assign sclk_en = !csn_q && (state_q != ST_DONE);

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (sclk_en),
      .sclk_o (flash_clk),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   always_comb begin
      state_d   = state_q;
      csn_d     = csn_q;
      mosi_d    = mosi_q;
      ack_d     = 1'b0;
      busy_d    = busy_q;
      data_d    = data_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_stb_i) begin
               state_d   = ST_CMD;
               busy_d    = 1'b1;
               csn_d     = 1'b0;
               tx_d      = {CMD, addr_i};
               mosi_d    = CMD[7];
               bit_cnt_d = 7'd7;
            end
         end
         ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
            if (sclk_rise && state_q == ST_DATA)
               rx_d = {rx_q[30:0], flash_miso};
            // Each falling edge closes a bit and presents the next one.
            if (sclk_fall) begin
               tx_d   = tx_q << 1;
               mosi_d = (state_q == ST_CMD || state_q == ST_ADDR) ? tx_q[30] : 1'b0;
               if (bit_cnt_q == 7'd0) begin
                  case (state_q)
                     ST_CMD: begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = 7'(FLASH_ADDR_BITS - 1);
                     end
                     ST_ADDR: begin
                        state_d   = HAS_DUMMY ? ST_DUMMY : ST_DATA;
                        bit_cnt_d = HAS_DUMMY ? 7'd7 : 7'd31;
                     end
                     ST_DUMMY: begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 7'd31;
                     end
                     default: state_d = ST_DONE;
                  endcase
               end else begin
                  bit_cnt_d = bit_cnt_q - 7'd1;
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_GAP;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            ack_d     = 1'b1;
            data_d    = bswap32(rx_q);
            gap_cnt_d = 8'(CS_GAP);
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         csn_q     <= 1'b1;
         mosi_q    <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         csn_q     <= csn_d;
         mosi_q    <= mosi_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign flash_csn   = csn_q;
   assign flash_mosi  = mosi_q;
   assign ack_o       = ack_q;
   assign busy_o      = busy_q;
   assign data_o      = data_q;
   assign flash_wpn   = 1'b1;
   assign flash_holdn = 1'b1;
endmodule
